// File: rtl/vend_pkg.sv
// Shared types for the vending front end: coin-buffer contents, debounce
// states, vending FSM states and the default debounce length.
package vend_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        C5   = 2'd1,
        C10  = 2'd2
    } coin_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } deb_state_e;

    typedef enum logic [1:0] {
        V_IDLE     = 2'd0,
        V_PAID5    = 2'd1,
        V_PAID10   = 2'd2,
        V_DISPENSE = 2'd3
    } vend_state_e;

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor channel: 2-flop synchroniser followed by a press/release
// debounce FSM that emits a registered one-cycle coin_event per insertion.
module coin_debounce
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic coin_event
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_meta;
    logic             synced;
    deb_state_e       state;
    deb_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             event_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            synced    <= 1'b0;
        end else begin
            sync_meta <= raw;
            synced    <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            coin_event <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            coin_event <= event_nxt;
        end
    end

    // A level must survive a full count before the FSM commits to it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        event_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (synced) begin
                    state_nxt = ARM;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ARM: begin
                if (!synced) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    event_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!synced) begin
                    state_nxt = REL;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            REL: begin
                if (synced) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: per-channel debounce, arbitration, one-entry
// pending buffer and registered pulses. COIN_ACCEPTOR_STATS_EN adds counters.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_5,
    input  logic             raw_10,
    input  logic             vend_busy,
    output logic             coin_5,
    output logic             coin_10,
    output logic             reject,
    output logic             pending,
    output logic [CNT_W-1:0] accepted_cnt,
    output logic [CNT_W-1:0] reject_cnt
);

    logic  ev_5;
    logic  ev_10;
    coin_e buf_q;
    coin_e buf_nxt;
    coin_e new_coin;
    coin_e deliver;
    logic  drained;
    logic  reject_nxt;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_5 (
        .clk        (clk),
        .reset      (reset),
        .raw        (raw_5),
        .coin_event (ev_5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_10 (
        .clk        (clk),
        .reset      (reset),
        .raw        (raw_10),
        .coin_event (ev_10)
    );

    // Drain goes first so a coin arriving in the same cycle can take the slot.
    always_comb begin
        buf_nxt    = buf_q;
        deliver    = NONE;
        drained    = 1'b0;
        reject_nxt = 1'b0;
        new_coin   = NONE;
        if (ev_5 && !ev_10) begin
            new_coin = C5;
        end else if (ev_10 && !ev_5) begin
            new_coin = C10;
        end
        if (!vend_busy && buf_q != NONE) begin
            deliver = buf_q;
            buf_nxt = NONE;
            drained = 1'b1;
        end
        if (ev_5 && ev_10) begin
            reject_nxt = 1'b1;
        end else if (new_coin != NONE) begin
            if (drained) begin
                buf_nxt = new_coin;
            end else if (buf_q != NONE) begin
                reject_nxt = 1'b1;
            end else if (vend_busy) begin
                buf_nxt = new_coin;
            end else begin
                deliver = new_coin;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q   <= NONE;
            coin_5  <= 1'b0;
            coin_10 <= 1'b0;
            reject  <= 1'b0;
            pending <= 1'b0;
        end else begin
            buf_q   <= buf_nxt;
            coin_5  <= (deliver == C5);
            coin_10 <= (deliver == C10);
            reject  <= reject_nxt;
            pending <= (buf_nxt != NONE);
        end
    end

`ifdef COIN_ACCEPTOR_STATS_EN
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] rej_q;

    // Saturating counters driven from the registered pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            rej_q <= '0;
        end else begin
            if ((coin_5 || coin_10) && acc_q != '1) begin
                acc_q <= acc_q + CNT_W'(1);
            end
            if (reject && rej_q != '1) begin
                rej_q <= rej_q + CNT_W'(1);
            end
        end
    end

    assign accepted_cnt = acc_q;
    assign reject_cnt   = rej_q;
`else
    assign accepted_cnt = '0;
    assign reject_cnt   = '0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor with DEBOUNCE_CYCLES=4: a run-length
// model checked every cycle plus directed scenarios with literal expectations.
module tb_coin_acceptor;

    localparam int unsigned D = 4;
    localparam int unsigned W = 8;
`ifdef COIN_ACCEPTOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         raw_5;
    logic         raw_10;
    logic         vend_busy;
    logic         coin_5;
    logic         coin_10;
    logic         reject;
    logic         pending;
    logic [W-1:0] accepted_cnt;
    logic [W-1:0] reject_cnt;

    coin_acceptor #(.DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_5        (raw_5),
        .raw_10       (raw_10),
        .vend_busy    (vend_busy),
        .coin_5       (coin_5),
        .coin_10      (coin_10),
        .reject       (reject),
        .pending      (pending),
        .accepted_cnt (accepted_cnt),
        .reject_cnt   (reject_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_c5, n_c10, n_rej, first_c5;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: sensor = 2-cycle delay; a coin is recognised on the (D+1)th
    // consecutive synced high and re-armed after D+1 consecutive lows.
    bit m_s1[2], m_s2[2], m_ev[2], m_held[2];
    int m_hi[2], m_lo[2];
    int m_buf, m_coin, m_acc, m_rcnt;
    bit m_rej;

    always @(posedge clk or negedge reset) begin
        int  nc;
        bit  drained;
        bit  raw_now[2];
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_ev[c] = 0; m_held[c] = 0;
                m_hi[c] = 0; m_lo[c] = 0;
            end
            m_buf = 0; m_coin = 0; m_rej = 0; m_acc = 0; m_rcnt = 0;
        end else begin
            if (m_coin != 0 && m_acc < 255) m_acc++;
            if (m_rej && m_rcnt < 255) m_rcnt++;
            nc = (m_ev[0] && !m_ev[1]) ? 5 : (m_ev[1] && !m_ev[0]) ? 10 : 0;
            m_coin = 0; m_rej = 0; drained = 0;
            if (!vend_busy && m_buf != 0) begin
                m_coin = m_buf; m_buf = 0; drained = 1;
            end
            if (m_ev[0] && m_ev[1]) m_rej = 1;
            else if (nc != 0) begin
                if (drained) m_buf = nc;
                else if (m_buf != 0) m_rej = 1;
                else if (vend_busy) m_buf = nc;
                else m_coin = nc;
            end
            raw_now[0] = raw_5;
            raw_now[1] = raw_10;
            for (int c = 0; c < 2; c++) begin
                m_ev[c] = 0;
                if (m_s2[c]) begin
                    m_lo[c] = 0;
                    m_hi[c]++;
                    if (m_hi[c] > int'(D) && !m_held[c]) begin
                        m_ev[c] = 1; m_held[c] = 1;
                    end
                end else begin
                    m_hi[c] = 0;
                    m_lo[c]++;
                    if (m_lo[c] > int'(D)) m_held[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = raw_now[c];
            end
        end
    end

    // Every-cycle comparison against the model, plus pulse bookkeeping.
    always @(negedge clk) begin
        check("coin_5", coin_5, m_coin == 5);
        check("coin_10", coin_10, m_coin == 10);
        check("reject", reject, m_rej);
        check("pending", pending, m_buf != 0);
        check("accepted_cnt", accepted_cnt, STATS ? m_acc : 0);
        check("reject_cnt", reject_cnt, STATS ? m_rcnt : 0);
        check("one_hot", coin_5 && coin_10, 0);
        if (coin_5) begin
            n_c5++;
            if (first_c5 < 0) first_c5 = cyc;
        end
        if (coin_10) n_c10++;
        if (reject) n_rej++;
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_c5 = 0; n_c10 = 0; n_rej = 0; first_c5 = -1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_coin_5"}, coin_5, 0);
        check({tag, "_coin_10"}, coin_10, 0);
        check({tag, "_reject"}, reject, 0);
        check({tag, "_pending"}, pending, 0);
    endtask

    task automatic insert(input bit c5, input bit c10, input int hold, input int gap);
        raw_5 = c5; raw_10 = c10;
        ticks(hold);
        raw_5 = 0; raw_10 = 0;
        ticks(gap);
    endtask

    initial begin
        int t0;
        reset = 0; raw_5 = 0; raw_10 = 0; vend_busy = 0;
        clear_counts();
        ticks(3);
        check_all_zero("reset_state");
        reset = 1;
        ticks(5);

        // Clean 5-unit insert and its latency.
        clear_counts();
        raw_5 = 1;
        t0 = cyc + 1;
        ticks(12);
        raw_5 = 0;
        ticks(15);
        check("clean_c5_count", n_c5, 1);
        check("clean_latency", first_c5 - t0, 7);
        check("clean_reject", n_rej, 0);
        check("clean_c10", n_c10, 0);

        // Glitchy 10-unit sensor.
        clear_counts();
        raw_10 = 1; ticks(3);
        raw_10 = 0; ticks(1);
        raw_10 = 1; ticks(3);
        raw_10 = 0; ticks(15);
        check("glitch_c10", n_c10, 0);
        check("glitch_reject", n_rej, 0);

        // Buffering while a vend is in progress.
        clear_counts();
        vend_busy = 1;
        insert(0, 1, 8, 10);
        check("buf_pending", pending, 1);
        check("buf_no_pulse", n_c10, 0);
        vend_busy = 0;
        ticks(1);
        check("drain_c10", coin_10, 1);
        check("drain_pending", pending, 0);
        ticks(5);
        check("drain_c10_count", n_c10, 1);

        // Overflow: second coin rejected, first kept.
        clear_counts();
        vend_busy = 1;
        insert(1, 0, 8, 10);
        insert(0, 1, 8, 10);
        check("ovf_reject", n_rej, 1);
        check("ovf_pending", pending, 1);
        vend_busy = 0;
        ticks(5);
        check("ovf_c5", n_c5, 1);
        check("ovf_c10", n_c10, 0);

        // Simultaneous insert from a clean reset.
        reset = 0; ticks(2); reset = 1; ticks(3);
        clear_counts();
        insert(1, 1, 8, 15);
        check("simul_reject", n_rej, 1);
        check("simul_c5", n_c5, 0);
        check("simul_c10", n_c10, 0);
        check("simul_reject_cnt", reject_cnt, STATS ? 1 : 0);

        // Reset mid-ARM.
        clear_counts();
        raw_5 = 1;
        ticks(4);
        reset = 0;
        #1;
        check_all_zero("rst_arm");
        raw_5 = 0;
        ticks(2);
        reset = 1;
        ticks(20);
        check("rst_arm_stale_c5", n_c5, 0);

        // Reset with a coin buffered, asserted between clock edges.
        clear_counts();
        vend_busy = 1;
        insert(0, 1, 8, 10);
        check("rst_buf_pending_before", pending, 1);
        @(posedge clk);
        #2 reset = 0;
        #1;
        check_all_zero("rst_buf");
        ticks(2);
        reset = 1;
        vend_busy = 0;
        ticks(10);
        check("rst_buf_stale_c10", n_c10, 0);
        check("rst_buf_pending_after", pending, 0);
        check("rst_buf_accepted_cnt", accepted_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
